// File: rtl/tcp_hdr_pkg.sv
// Shared constants for the TCP header streamer: record layout, protocol constants, FSM states.
package tcp_hdr_pkg;

  // Word offsets inside one connection record
  localparam int W_CTRL    = 0;  // [31] valid, [29:24] tcp_flags, [15:0] window
  localparam int W_SEQ     = 1;
  localparam int W_ACK     = 2;
  localparam int W_IP_SRC  = 3;
  localparam int W_IP_DST  = 4;
  localparam int W_MAC_A   = 5;  // mac_src[47:16]
  localparam int W_MAC_B   = 6;  // {mac_src[15:0], mac_dst[47:32]}
  localparam int W_MAC_C   = 7;  // mac_dst[31:0]
  localparam int W_PORTS   = 8;  // {src_port, dst_port}
  localparam int REC_WORDS = 9;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_PROTO_TCP   = 8'h06;
  localparam int          HDR_WORDS      = 14;
  // Largest payload whose IPv4 total length (payload + 40) still fits in 16 bits
  localparam logic [15:0] MAX_TCP_LEN    = 16'd65495;

  typedef enum logic [2:0] {S_IDLE, S_RD, S_CSUM, S_EMIT, S_ERR} state_t;

endpackage

// File: rtl/tcp_hdr_streamer_if.sv
// Request, connection-RAM and header-stream signals of the TCP header streamer.
interface tcp_hdr_streamer_if #(
    parameter int N_CONN = 8,
    parameter int ADDR_W = 9
);
  localparam int IDX_W = (N_CONN > 1) ? $clog2(N_CONN) : 1;

  logic              req_valid;
  logic              req_ready;
  logic [IDX_W-1:0]  req_idx;
  logic [15:0]       req_len;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_rdata;
  logic [31:0]       hdr_data;
  logic              hdr_valid;
  logic              hdr_ready;
  logic              hdr_last;
  logic [2:0]        hdr_bytes;
  logic              err_pulse;

  // master: the streamer itself; slave: requester, RAM and framer side
  modport master (
    input  req_valid, req_idx, req_len, ram_rdata, hdr_ready,
    output req_ready, ram_addr, hdr_data, hdr_valid, hdr_last, hdr_bytes, err_pulse
  );
  modport slave (
    output req_valid, req_idx, req_len, ram_rdata, hdr_ready,
    input  req_ready, ram_addr, hdr_data, hdr_valid, hdr_last, hdr_bytes, err_pulse
  );
endinterface

// File: rtl/tcp_hdr_streamer_ip_csum16.sv
// IPv4 header checksum: sums halfwords on start, folds and inverts; done two cycles later.
module ip_csum16 #(
    parameter int N_HW = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [N_HW-1:0][15:0] hw,
    output logic                 done,
    output logic [15:0]          csum
);
  localparam int STAGES = 2;

  logic [STAGES:1] vld_pipe;
  logic [31:0]     sum, sum_q, fold1;
  logic [16:0]     fold2;

  always_comb begin
    sum = '0;
    for (int i = 0; i < N_HW; i++) sum = sum + 32'(hw[i]);
  end

  // fold1 is at most 0x1FFFE, so the second fold cannot carry again
  assign fold1 = 32'(sum_q[31:16]) + 32'(sum_q[15:0]);
  assign fold2 = 17'(fold1[15:0]) + 17'(fold1[31:16]);

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      sum_q    <= '0;
      csum     <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], start};
      if (start)       sum_q <= sum;
      if (vld_pipe[1]) csum  <= ~fold2[15:0];
    end
  end

  assign done = vld_pipe[STAGES];

endmodule

// File: rtl/tcp_hdr_streamer.sv
// Reads one connection record, builds the 54-byte Eth/IPv4/TCP header and streams it as 14 words.
module tcp_hdr_streamer
  import tcp_hdr_pkg::*;
#(
    parameter int N_CONN     = 8,
    parameter int REC_STRIDE = 32,
    parameter int ADDR_W     = 9,
    parameter int IP_TTL     = 64
) (
    input logic                clk,
    input logic                rst,
    tcp_hdr_streamer_if.master bus
);
  state_t state, state_nx;

  logic [3:0]            cnt, wcnt;
  logic [15:0]           len, ip_id, csum, tot_len;
  logic                  idx_bad, rec_bad, csum_start, csum_done, hs, last;
  logic [ADDR_W-1:0]     ram_addr;
  logic [8:0][31:0]      rec;
  logic [9:0][15:0]      hw;
  logic [31:0]           word;
  logic                  unused_bits;

  assign tot_len     = len + 16'd40;
  assign last        = (wcnt == 4'(HDR_WORDS - 1));
  assign hs          = bus.hdr_valid && bus.hdr_ready;
  assign rec_bad     = !bus.ram_rdata[31] || idx_bad || (len > MAX_TCP_LEN);
  assign unused_bits = ^{rec[W_CTRL][31:30], rec[W_CTRL][23:16]};

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // cnt==1 is the cycle word 0 arrives; cnt==REC_WORDS is the last capture
  always_comb begin
    state_nx   = state;
    csum_start = 1'b0;
    unique case (state)
      S_IDLE: if (bus.req_valid) state_nx = S_RD;
      S_RD: begin
        if (cnt == 4'd1 && rec_bad) state_nx = S_ERR;
        else if (cnt == 4'(REC_WORDS)) begin
          state_nx   = S_CSUM;
          csum_start = 1'b1;
        end
      end
      S_CSUM: if (csum_done) state_nx = S_EMIT;
      S_EMIT: if (hs && last) state_nx = S_IDLE;
      S_ERR:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ram_addr <= '0;
      cnt      <= '0;
      wcnt     <= '0;
      len      <= '0;
      idx_bad  <= 1'b0;
      ip_id    <= '0;
      rec      <= '0;
    end else begin
      unique case (state)
        S_IDLE: if (bus.req_valid) begin
          ram_addr <= ADDR_W'(int'(bus.req_idx) * REC_STRIDE);
          cnt      <= '0;
          len      <= bus.req_len;
          idx_bad  <= (int'(bus.req_idx) >= N_CONN);
        end
        S_RD: begin
          ram_addr <= ram_addr + 1'b1;
          cnt      <= cnt + 4'd1;
          if (cnt != 4'd0) rec[cnt - 4'd1] <= bus.ram_rdata;
        end
        S_CSUM: wcnt <= '0;
        S_EMIT: if (hs) begin
          wcnt <= wcnt + 4'd1;
          if (last) ip_id <= ip_id + 16'd1;
        end
        default: ;
      endcase
    end
  end

  // IPv4 header halfwords with the checksum field as zero
  assign hw = {16'h4500, tot_len, ip_id, 16'h4000, {8'(IP_TTL), IP_PROTO_TCP}, 16'h0000,
               rec[W_IP_SRC][31:16], rec[W_IP_SRC][15:0],
               rec[W_IP_DST][31:16], rec[W_IP_DST][15:0]};

  ip_csum16 #(.N_HW(10)) u_csum (
    .clk   (clk),
    .rst   (rst),
    .start (csum_start),
    .hw    (hw),
    .done  (csum_done),
    .csum  (csum)
  );

  always_comb begin
    word = '0;
    case (wcnt)
      4'd0:  word = {rec[W_MAC_B][15:0], rec[W_MAC_C][31:16]};
      4'd1:  word = {rec[W_MAC_C][15:0], rec[W_MAC_A][31:16]};
      4'd2:  word = {rec[W_MAC_A][15:0], rec[W_MAC_B][31:16]};
      4'd3:  word = {ETHERTYPE_IPV4, 16'h4500};
      4'd4:  word = {tot_len, ip_id};
      4'd5:  word = {16'h4000, 8'(IP_TTL), IP_PROTO_TCP};
      4'd6:  word = {csum, rec[W_IP_SRC][31:16]};
      4'd7:  word = {rec[W_IP_SRC][15:0], rec[W_IP_DST][31:16]};
      4'd8:  word = {rec[W_IP_DST][15:0], rec[W_PORTS][31:16]};
      4'd9:  word = {rec[W_PORTS][15:0], rec[W_SEQ][31:16]};
      4'd10: word = {rec[W_SEQ][15:0], rec[W_ACK][31:16]};
      4'd11: word = {rec[W_ACK][15:0], 8'h50, 2'b00, rec[W_CTRL][29:24]};
      4'd12: word = {rec[W_CTRL][15:0], 16'h0000};
      default: word = '0;
    endcase
  end

  assign bus.req_ready = (state == S_IDLE);
  assign bus.err_pulse = (state == S_ERR);
  assign bus.ram_addr  = ram_addr;
  assign bus.hdr_valid = (state == S_EMIT);
  assign bus.hdr_last  = (state == S_EMIT) && last;
  assign bus.hdr_data  = (state == S_EMIT) ? word : '0;
  assign bus.hdr_bytes = (state != S_EMIT) ? 3'd0 : (last ? 3'd2 : 3'd4);

endmodule

// File: tb/tb_tcp_hdr_streamer.sv
// Directed + randomized bench for tcp_hdr_streamer against a byte-level header model.
module tb_tcp_hdr_streamer;
  localparam int N_CONN = 8, REC_STRIDE = 32, ADDR_W = 9;
  localparam int IDXW = $clog2(N_CONN);

  typedef struct packed {
    logic        valid;
    logic [5:0]  flags;
    logic [15:0] window;
    logic [31:0] seq, ack, ip_src, ip_dst;
    logic [47:0] mac_src, mac_dst;
    logic [15:0] sport, dport;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tcp_hdr_streamer_if #(.N_CONN(N_CONN), .ADDR_W(ADDR_W)) bus ();

  tcp_hdr_streamer #(.N_CONN(N_CONN), .REC_STRIDE(REC_STRIDE), .ADDR_W(ADDR_W), .IP_TTL(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) bus.ram_rdata <= mem[bus.ram_addr];

  int          n_vec = 0, n_err = 0;
  logic [15:0] model_id = 16'h0;
  logic [31:0] exp_w [14];
  logic [31:0] got_w [14];
  rec_t        recs [N_CONN];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic rec_t rand_rec();
    rec_t r;
    r.valid   = 1'b1;
    r.flags   = 6'($urandom);
    r.window  = 16'($urandom);
    r.seq     = $urandom;
    r.ack     = $urandom;
    r.ip_src  = $urandom;
    r.ip_dst  = $urandom;
    r.mac_src = {16'($urandom), $urandom};
    r.mac_dst = {16'($urandom), $urandom};
    r.sport   = 16'($urandom);
    r.dport   = 16'($urandom);
    return r;
  endfunction

  // Don't-care bits of word 0 get junk so the DUT must ignore them
  task automatic write_rec(input int idx, input rec_t r);
    int b;
    b = idx * REC_STRIDE;
    recs[idx]  = r;
    mem[b + 0] = {r.valid, 1'($urandom), r.flags, 8'($urandom), r.window};
    mem[b + 1] = r.seq;
    mem[b + 2] = r.ack;
    mem[b + 3] = r.ip_src;
    mem[b + 4] = r.ip_dst;
    mem[b + 5] = r.mac_src[47:16];
    mem[b + 6] = {r.mac_src[15:0], r.mac_dst[47:32]};
    mem[b + 7] = r.mac_dst[31:0];
    mem[b + 8] = {r.sport, r.dport};
  endtask

  // Whole packet header as a byte string, checksum over IPv4 bytes 14..33, then cut into words
  task automatic build_exp(input rec_t r, input logic [15:0] len, input logic [15:0] id);
    logic [54*8-1:0] h;
    logic [56*8-1:0] hp;
    logic [31:0]     s;
    h = {r.mac_dst, r.mac_src, 16'h0800, 8'h45, 8'h00, 16'(len + 16'd40), id,
         16'h4000, 8'd64, 8'h06, 16'h0000, r.ip_src, r.ip_dst, r.sport, r.dport,
         r.seq, r.ack, 8'h50, {2'b00, r.flags}, r.window, 16'h0000, 16'h0000};
    s = 0;
    for (int i = 0; i < 10; i++) s = s + 32'(h[(40*8-1) - 16*i -: 16]);
    while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
    h[(30*8-1) -: 16] = ~s[15:0];
    hp = {h, 16'h0000};
    for (int i = 0; i < 14; i++) exp_w[i] = hp[(56*8-1) - 32*i -: 32];
  endtask

  task automatic req_hdr(input int idx, input logic [15:0] len, input int bp,
                         input int abort_at, input string tag);
    int lat, n, guard;
    bit r;
    build_exp(recs[idx], len, model_id);
    bus.req_idx   = idx[IDXW-1:0];
    bus.req_len   = len;
    bus.req_valid = 1'b1;
    chk({tag, "_req_ready"}, 64'(bus.req_ready), 64'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk({tag, "_addr0"}, 64'(bus.ram_addr), 64'(idx * REC_STRIDE));
    lat = 0;
    while (!bus.hdr_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'd12);
    n = 0;
    guard = 0;
    while (n < 14 && guard < 400) begin
      if (abort_at >= 0 && n == abort_at && bus.hdr_valid) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk({tag, "_abort_valid"}, 64'(bus.hdr_valid), 64'd0);
        chk({tag, "_abort_ready"}, 64'(bus.req_ready), 64'd1);
        model_id = 16'h0;
        return;
      end
      r = ($urandom_range(99) >= 32'(bp));
      bus.hdr_ready = r;
      if (bus.hdr_valid) begin
        chk($sformatf("%s_w%0d", tag, n), {28'd0, bus.hdr_data, bus.hdr_last, bus.hdr_bytes},
            {28'd0, exp_w[n], (n == 13), (n == 13) ? 3'd2 : 3'd4});
        if (r) begin
          got_w[n] = bus.hdr_data;
          n++;
        end
      end
      @(negedge clk);
      guard++;
    end
    chk({tag, "_nwords"}, 64'(n), 64'd14);
    chk({tag, "_end_valid"}, 64'(bus.hdr_valid), 64'd0);
    chk({tag, "_end_ready"}, 64'(bus.req_ready), 64'd1);
    model_id = model_id + 16'd1;
  endtask

  task automatic err_req(input int idx, input logic [15:0] len, input string tag);
    int errs, vld, rdy_lat;
    bus.req_idx   = idx[IDXW-1:0];
    bus.req_len   = len;
    bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk({tag, "_addr0"}, 64'(bus.ram_addr), 64'(idx * REC_STRIDE));
    errs = 0; vld = 0; rdy_lat = 0;
    for (int c = 0; c < 12; c++) begin
      if (bus.err_pulse) errs++;
      if (bus.hdr_valid) vld++;
      if (rdy_lat == 0 && bus.req_ready) rdy_lat = c;
      @(negedge clk);
    end
    chk({tag, "_err_count"}, 64'(errs), 64'd1);
    chk({tag, "_no_valid"}, 64'(vld), 64'd0);
    chk({tag, "_ready_back"}, 64'(rdy_lat >= 1 && rdy_lat <= 3), 64'd1);
  endtask

  initial begin
    rec_t r0;
    int idx;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'h0;
    bus.req_valid = 1'b0;
    bus.req_idx   = '0;
    bus.req_len   = 16'h0;
    bus.hdr_ready = 1'b0;
    for (int i = 0; i < N_CONN; i++) write_rec(i, rand_rec());
    r0 = rand_rec();
    r0.mac_dst = 48'h001122334455;
    r0.mac_src = 48'h66778899AABB;
    r0.ip_src  = 32'h0A000001;
    r0.ip_dst  = 32'h0A000002;
    r0.sport   = 16'h1F90;
    r0.dport   = 16'h0050;
    write_rec(0, r0);
    r0 = rand_rec();
    r0.valid = 1'b0;
    write_rec(3, r0);

    repeat (3) @(negedge clk);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
    chk("rst_hdr_valid", 64'(bus.hdr_valid), 64'd0);
    chk("rst_hdr_last",  64'(bus.hdr_last),  64'd0);
    chk("rst_hdr_bytes", 64'(bus.hdr_bytes), 64'd0);
    chk("rst_hdr_data",  64'(bus.hdr_data),  64'd0);
    chk("rst_err_pulse", 64'(bus.err_pulse), 64'd0);
    chk("rst_ram_addr",  64'(bus.ram_addr),  64'd0);
    rst = 1'b0;
    @(negedge clk);

    req_hdr(0, 16'd0, 0, -1, "t1");
    chk("t1_w3", 64'(got_w[3]), 64'h08004500);
    chk("t1_w4", 64'(got_w[4]), 64'h00280000);
    chk("t1_w5", 64'(got_w[5]), 64'h40004006);
    chk("t1_w6", 64'(got_w[6]), 64'h26CE0A00);

    req_hdr(0, 16'd0, 0, -1, "t2");
    chk("t2_w4", 64'(got_w[4]), 64'h00280001);
    chk("t2_csum", 64'(got_w[6][31:16]), 64'h26CD);

    err_req(3, 16'd0, "t3");

    req_hdr(0, 16'd0, 50, -1, "t4");

    req_hdr(0, 16'd0, 0, 6, "t5");
    req_hdr(1, 16'd100, 0, -1, "t5b");
    chk("t5b_id_after_rst", 64'(got_w[4][15:0]), 64'h0000);

    err_req(0, 16'd65496, "t6a");
    req_hdr(0, 16'd65495, 0, -1, "t6b");
    chk("t6b_totlen", 64'(got_w[4][31:16]), 64'hFFFF);

    force dut.ip_id = 16'hFFFF;
    @(negedge clk);
    release dut.ip_id;
    model_id = 16'hFFFF;
    req_hdr(2, 16'($urandom_range(1500)), 0, -1, "t6c");
    chk("t6c_id", 64'(got_w[4][15:0]), 64'hFFFF);
    req_hdr(2, 16'($urandom_range(1500)), 0, -1, "t6d");
    chk("t6d_id_wrap", 64'(got_w[4][15:0]), 64'h0000);

    for (int k = 0; k < 6; k++) begin
      idx = $urandom_range(N_CONN - 1);
      if (idx == 3) idx = 4;
      req_hdr(idx, 16'($urandom_range(2000)), $urandom_range(70), -1, $sformatf("rnd%0d", k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
